// File: rtl/pong_pkg.sv
// Shared codes for the Pong audio path: channel/sound request encoding,
// FSM state type and elaboration-time helpers.
package pong_pkg;

  localparam logic [1:0] CH_NONE  = 2'd0;
  localparam logic [1:0] CH_RIGHT = 2'd1;
  localparam logic [1:0] CH_LEFT  = 2'd2;
  localparam logic [1:0] CH_BOTH  = 2'd3;

  localparam logic [1:0] SND_NONE = 2'd0;
  localparam logic [1:0] SND_PING = 2'd1;
  localparam logic [1:0] SND_PONG = 2'd2;
  localparam logic [1:0] SND_GOAL = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAY    = 2'd1,
    ST_LOCKOUT = 2'd2
  } state_e;

  typedef struct packed {
    logic [1:0] ch;
    logic [1:0] snd;
  } req_t;

  // Half period of a square wave in clk cycles.
  function automatic int half_period(input int clk_hz, input int f_hz);
    return clk_hz / (2 * f_hz);
  endfunction

  // A request is only meaningful with both a channel and a sound.
  function automatic logic req_valid(input req_t r);
    return (r.ch != CH_NONE) && (r.snd != SND_NONE);
  endfunction

endpackage

// File: rtl/square_osc.sv
// Square-wave oscillator: toggles tone every half_period cycles while en.
// restart forces tone high with a fresh count; clr only re-phases the count.
module square_osc #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] half_period,
  input  logic         restart,
  input  logic         en,
  input  logic         clr,
  output logic         tone_nxt
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         tone_q, tone_d;
  logic         term;

  assign term     = (cnt_q + ONE) == half_period;
  assign tone_nxt = tone_d;

  // Next count / tone; a terminal count still toggles even when clr re-phases.
  always_comb begin
    cnt_d  = cnt_q;
    tone_d = tone_q;
    if (restart) begin
      cnt_d  = '0;
      tone_d = 1'b1;
    end else if (en) begin
      if (term) tone_d = ~tone_q;
      cnt_d = (term || clr) ? '0 : cnt_q + ONE;
    end
  end

  // Oscillator state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      tone_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tone_q <= tone_d;
    end
  end

endmodule

// File: rtl/pong_sound_gen.sv
// Pong audio back-end: resynchronises the dynamics-stage request, runs the
// IDLE/PLAY/LOCKOUT sequencer with min/max duration, and drives registered
// square-wave outputs (goal sound warbles between two pitches).
module pong_sound_gen
  import pong_pkg::*;
#(
  parameter int CLK_HZ     = 25000000,
  parameter int PING_HZ    = 880,
  parameter int PONG_HZ    = 440,
  parameter int GOAL_HI_HZ = 1320,
  parameter int GOAL_LO_HZ = 660,
  parameter int WARBLE_MS  = 50,
  parameter int MIN_MS     = 20,
  parameter int MAX_MS     = 500
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] channel,
  input  logic [1:0] sound,
  input  logic       mute,
  output logic       audio_l,
  output logic       audio_r,
  output logic       active
);

  localparam int PRE     = CLK_HZ / 1000;
  localparam int PW      = $clog2(PRE + 1);
  localparam int MSW     = $clog2(MAX_MS + 2);
  localparam int WW      = $clog2(WARBLE_MS + 1);
  localparam int HP_PING = half_period(CLK_HZ, PING_HZ);
  localparam int HP_PONG = half_period(CLK_HZ, PONG_HZ);
  localparam int HP_GHI  = half_period(CLK_HZ, GOAL_HI_HZ);
  localparam int HP_GLO  = half_period(CLK_HZ, GOAL_LO_HZ);
  localparam int HP_M1   = (HP_PING > HP_PONG) ? HP_PING : HP_PONG;
  localparam int HP_M2   = (HP_GHI > HP_GLO) ? HP_GHI : HP_GLO;
  localparam int HP_MAX  = (HP_M1 > HP_M2) ? HP_M1 : HP_M2;
  localparam int HPW     = $clog2(HP_MAX) + 1;

  req_t           syn1_q, syn2_q, req_q;
  req_t           cur_q, cur_d;
  state_e         state_q, state_d;
  logic           load;
  logic [PW-1:0]  pre_q;
  logic [MSW-1:0] ms_q, ms_nxt;
  logic [WW-1:0]  warb_q;
  logic           ghi_q;
  logic           tick, in_play, warb_sw, min_done, max_hit, rvalid;
  logic [HPW-1:0] hp;
  logic           tone_nxt;
  logic           audio_l_d, audio_r_d, active_d;

  // Two-flop synchroniser, then only accept a request seen twice in a row.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      syn1_q <= '0;
      syn2_q <= '0;
      req_q  <= '0;
    end else begin
      syn1_q <= req_t'({channel, sound});
      syn2_q <= syn1_q;
      if (syn1_q == syn2_q) req_q <= syn2_q;
    end
  end

  assign rvalid   = req_valid(req_q);
  assign in_play  = (state_q == ST_PLAY);
  assign tick     = in_play && (pre_q == PW'(PRE - 1));
  assign ms_nxt   = ms_q + MSW'(tick);
  // Durations are judged on the count as it will be after this cycle's tick,
  // so MIN_MS/MAX_MS land exactly on the ms boundary.
  assign min_done = ms_nxt >= MSW'(MIN_MS);
  assign max_hit  = ms_nxt >= MSW'(MAX_MS);
  assign warb_sw  = tick && (warb_q == WW'(WARBLE_MS - 1));
  assign cur_d    = load ? req_q : cur_q;

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // FSM next state; load marks PLAY entry or retrigger.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rvalid) begin
          state_d = ST_PLAY;
          load    = 1'b1;
        end
      end
      ST_PLAY: begin
        if (!rvalid) begin
          if (min_done) state_d = ST_IDLE;
        end else if (max_hit) begin
          state_d = ST_LOCKOUT;
        end else if (req_q != cur_q) begin
          load = 1'b1;
        end
      end
      ST_LOCKOUT: begin
        if (!rvalid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs, computed from next-state values so the register adds no lag.
  always_comb begin
    active_d  = (state_d == ST_PLAY);
    audio_l_d = active_d && tone_nxt && cur_d.ch[1] && !mute;
    audio_r_d = active_d && tone_nxt && cur_d.ch[0] && !mute;
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      audio_l <= 1'b0;
      audio_r <= 1'b0;
      active  <= 1'b0;
    end else begin
      audio_l <= audio_l_d;
      audio_r <= audio_r_d;
      active  <= active_d;
    end
  end

  // Current request, ms prescaler, duration counter and warble phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_q  <= '0;
      pre_q  <= '0;
      ms_q   <= '0;
      warb_q <= '0;
      ghi_q  <= 1'b0;
    end else if (load) begin
      cur_q  <= req_q;
      pre_q  <= '0;
      ms_q   <= '0;
      warb_q <= '0;
      ghi_q  <= 1'b1;
    end else if (in_play) begin
      pre_q <= tick ? '0 : pre_q + PW'(1);
      if (tick) begin
        ms_q <= ms_nxt;
        if (warb_sw) begin
          warb_q <= '0;
          ghi_q  <= ~ghi_q;
        end else begin
          warb_q <= warb_q + WW'(1);
        end
      end
    end
  end

  // Half-period select for the tone being played.
  always_comb begin
    case (cur_q.snd)
      SND_PING: hp = HPW'(HP_PING);
      SND_PONG: hp = HPW'(HP_PONG);
      default:  hp = ghi_q ? HPW'(HP_GHI) : HPW'(HP_GLO);
    endcase
  end

  square_osc #(.W(HPW)) u_osc (
    .clk         (clk),
    .reset_n     (reset_n),
    .half_period (hp),
    .restart     (load),
    .en          (in_play),
    .clr         (warb_sw && (cur_q.snd == SND_GOAL)),
    .tone_nxt    (tone_nxt)
  );

endmodule

// File: tb/tb_pong_sound_gen.sv
// Directed bench for pong_sound_gen with a 100 kHz clock (1 ms = 100 clk).
module tb_pong_sound_gen;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] channel, sound;
  logic       mute;
  logic       audio_l, audio_r, active;

  int checks = 0;
  int errors = 0;

  pong_sound_gen #(
    .CLK_HZ(100000), .PING_HZ(1000), .PONG_HZ(500),
    .GOAL_HI_HZ(2000), .GOAL_LO_HZ(1000),
    .WARBLE_MS(2), .MIN_MS(3), .MAX_MS(20)
  ) dut (
    .clk(clk), .reset_n(reset_n), .channel(channel), .sound(sound),
    .mute(mute), .audio_l(audio_l), .audio_r(audio_r), .active(active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] ch;
    logic [1:0] snd;
    logic       m;
    int         w;
    logic [2:0] exp_lra;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [1:0] ch, input logic [1:0] snd, input logic m,
                     input int w, input logic [2:0] lra);
    vec_t v;
    v.ch = ch; v.snd = snd; v.m = m; v.w = w; v.exp_lra = lra;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got l/r/active=%b expected %b", nm, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic seen;
    reset_n = 1'b0; channel = 2'd0; sound = 2'd0; mute = 1'b0;
    clks(3);
    chk("reset state", {audio_l, audio_r, active}, 3'b000);
    reset_n = 1'b1;

    // Asynchronous reset in the middle of a tone.
    channel = 2'd3; sound = 2'd1;
    clks(10);
    chk("tone before reset", {audio_l, audio_r, active}, 3'b111);
    #2 reset_n = 1'b0;
    #1 chk("async reset drop", {audio_l, audio_r, active}, 3'b000);
    channel = 2'd0; sound = 2'd0;
    clks(1);
    reset_n = 1'b1;
    clks(8);
    chk("idle after reset", {audio_l, audio_r, active}, 3'b000);

    // One-cycle glitch must be rejected by the stability filter.
    channel = 2'd3; sound = 2'd1;
    clks(1);
    channel = 2'd0; sound = 2'd0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      clks(1);
      seen = seen | active | audio_l | audio_r;
    end
    chk("glitch filtered", {2'b00, seen}, 3'b000);

    // Ping on both channels: 4 clk latency, 50/50 pattern, release.
    add(2'd3, 2'd1, 1'b0,   3, 3'b000);
    add(2'd3, 2'd1, 1'b0,   1, 3'b111);
    add(2'd3, 2'd1, 1'b0,  49, 3'b111);
    add(2'd3, 2'd1, 1'b0,   1, 3'b001);
    add(2'd3, 2'd1, 1'b0,  49, 3'b001);
    add(2'd3, 2'd1, 1'b0,   1, 3'b111);
    add(2'd3, 2'd1, 1'b0, 899, 3'b001);
    add(2'd0, 2'd0, 1'b0,   3, 3'b111);
    add(2'd0, 2'd0, 1'b0,   1, 3'b000);
    // Pong on left for 1 ms: minimum duration stretches it to 3 ms.
    add(2'd2, 2'd2, 1'b0,   4, 3'b101);
    add(2'd2, 2'd2, 1'b0,  96, 3'b101);
    add(2'd0, 2'd0, 1'b0,   4, 3'b001);
    add(2'd0, 2'd0, 1'b0, 100, 3'b101);
    add(2'd0, 2'd0, 1'b0,  99, 3'b101);
    add(2'd0, 2'd0, 1'b0,   1, 3'b000);
    // Goal on right: 25-clk half period for 2 ms, then 50, then back.
    add(2'd1, 2'd3, 1'b0,   4, 3'b011);
    add(2'd1, 2'd3, 1'b0,  24, 3'b011);
    add(2'd1, 2'd3, 1'b0,   1, 3'b001);
    add(2'd1, 2'd3, 1'b0, 175, 3'b011);
    add(2'd1, 2'd3, 1'b0,  49, 3'b011);
    add(2'd1, 2'd3, 1'b0,   1, 3'b001);
    add(2'd1, 2'd3, 1'b0, 150, 3'b011);
    add(2'd1, 2'd3, 1'b0,  25, 3'b001);
    add(2'd0, 2'd0, 1'b0,   4, 3'b000);
    // Retrigger ping -> pong while playing.
    add(2'd3, 2'd1, 1'b0,   4, 3'b111);
    add(2'd3, 2'd1, 1'b0,  50, 3'b001);
    add(2'd3, 2'd1, 1'b0,  10, 3'b001);
    add(2'd3, 2'd2, 1'b0,   3, 3'b001);
    add(2'd3, 2'd2, 1'b0,   1, 3'b111);
    add(2'd3, 2'd2, 1'b0,  50, 3'b111);
    add(2'd3, 2'd2, 1'b0,  49, 3'b111);
    add(2'd3, 2'd2, 1'b0,   1, 3'b001);
    // Held request: lockout at 20 ms from retrigger, stays silent.
    add(2'd3, 2'd2, 1'b0, 1899, 3'b001);
    add(2'd3, 2'd2, 1'b0,    1, 3'b000);
    add(2'd3, 2'd2, 1'b0, 1000, 3'b000);
    add(2'd0, 2'd0, 1'b0,    4, 3'b000);
    // New request after release plays; mute silences audio but not active.
    add(2'd3, 2'd1, 1'b1,   4, 3'b001);
    add(2'd3, 2'd1, 1'b1,  30, 3'b001);
    add(2'd3, 2'd1, 1'b0,   5, 3'b111);
    add(2'd0, 2'd0, 1'b0, 270, 3'b000);

    foreach (tbl[i]) begin
      channel = tbl[i].ch; sound = tbl[i].snd; mute = tbl[i].m;
      clks(tbl[i].w);
      chk($sformatf("vec%0d", i), {audio_l, audio_r, active}, tbl[i].exp_lra);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
